// File: rtl/r_ram_to_uart_pkg.sv
// Shared definitions for the RAM-to-UART dump block: FSM encoding, default
// parameters and the baud divisor derivation.
package r_ram_to_uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_WAIT = 3'd2,
    LOAD    = 3'd3,
    TX_WAIT = 3'd4,
    NEXT    = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam int DEF_FULL_NUMBER = 6416;
  localparam int DEF_CLK_FREQ    = 50000000;
  localparam int DEF_UART_BPS    = 115200;

  // Cycles per bit; integer division truncates (434 at the defaults).
  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/r_ram_to_uart_uart_tx.sv
// 8N1 serial transmitter, LSB first, idle high. tx_en is accepted only while
// idle; tx_busy stays high through the end of the stop bit.
module uart_tx
  import r_ram_to_uart_pkg::*;
#(
  parameter int BPS_CNT = calc_bps_cnt(DEF_CLK_FREQ, DEF_UART_BPS)
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tx_en,
  input  logic [7:0] tx_data,
  output logic       uart_txd,
  output logic       tx_busy
);

  localparam int CNT_W = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BPS_CNT - 1);

  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       data_q;

  // bit_cnt: 0 = start, 1..8 = data[0..7], 9 = stop.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      data_q   <= '0;
    end else if (!tx_busy) begin
      if (tx_en) begin
        tx_busy  <= 1'b1;
        data_q   <= tx_data;
        uart_txd <= 1'b0;
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end
    end else if (baud_cnt == BAUD_LAST) begin
      baud_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        tx_busy  <= 1'b0;
        bit_cnt  <= '0;
        uart_txd <= 1'b1;
      end else begin
        bit_cnt  <= bit_cnt + 4'd1;
        // Drive the level of the bit being entered (bit_cnt + 1).
        uart_txd <= (bit_cnt == 4'd8) ? 1'b1 : data_q[bit_cnt[2:0]];
      end
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/r_ram_to_uart.sv
// Reads FULL_NUMBER bytes from a synchronous RAM in address order and sends
// each one over the UART; raises the end flag once the run is complete.
module r_ram_to_uart
  import r_ram_to_uart_pkg::*;
#(
  parameter int FULL_NUMBER = DEF_FULL_NUMBER,
  parameter int CLK_FREQ    = DEF_CLK_FREQ,
  parameter int UART_BPS    = DEF_UART_BPS
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        r_ram_to_uart_start,
  input  logic [7:0]  ram_dout,
  output logic [14:0] address,
  output logic        uart_txd,
  output logic        r_ram_to_uart_end
);

  localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [14:0] LAST_ADDR = 15'(FULL_NUMBER - 1);

  state_t      state, state_next;
  logic [14:0] counter;
  logic [7:0]  tx_data;
  logic        run_end;
  logic        tx_en;
  logic        tx_busy;
  logic        tx_busy_d;

  assign address           = counter;
  assign r_ram_to_uart_end = run_end;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_en      = 1'b0;
    case (state)
      IDLE:    if (r_ram_to_uart_start && !run_end) state_next = RD_ADDR;
      RD_ADDR: state_next = RD_WAIT;
      RD_WAIT: state_next = LOAD;
      LOAD: begin
        tx_en      = 1'b1;
        state_next = TX_WAIT;
      end
      // Falling edge of tx_busy marks the stop bit as fully sent.
      TX_WAIT: if (tx_busy_d && !tx_busy) state_next = NEXT;
      NEXT:    state_next = (counter == LAST_ADDR) ? DONE : RD_ADDR;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      counter   <= '0;
      tx_data   <= '0;
      run_end   <= 1'b0;
      tx_busy_d <= 1'b0;
    end else begin
      tx_busy_d <= tx_busy;
      case (state)
        // The end flag holds until start is seen low, blocking a rerun.
        IDLE:    if (run_end && !r_ram_to_uart_start) run_end <= 1'b0;
        RD_WAIT: tx_data <= ram_dout;
        NEXT:    if (counter != LAST_ADDR) counter <= counter + 15'd1;
        DONE: begin
          counter <= '0;
          run_end <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  uart_tx #(
    .BPS_CNT (BPS_CNT)
  ) u_uart_tx (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .uart_txd  (uart_txd),
    .tx_busy   (tx_busy)
  );

endmodule

// File: tb/tb_r_ram_to_uart.sv
// Directed bench for r_ram_to_uart: decodes the serial line cycle by cycle
// against hand-computed frames of a four-byte RAM image.
module tb_r_ram_to_uart;

  localparam int BPS   = 16;
  localparam int FRAME = 10 * BPS;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        start;
  logic [7:0]  ram_dout;
  logic [14:0] address;
  logic        uart_txd;
  logic        run_end;

  logic [7:0]  mem [0:3];
  logic [7:0]  exp_q [$];
  int          n_checks;
  int          n_errors;

  r_ram_to_uart #(
    .FULL_NUMBER (4),
    .CLK_FREQ    (16),
    .UART_BPS    (1)
  ) dut (
    .sys_clk             (sys_clk),
    .sys_rst_n           (sys_rst_n),
    .r_ram_to_uart_start (start),
    .ram_dout            (ram_dout),
    .address             (address),
    .uart_txd            (uart_txd),
    .r_ram_to_uart_end   (run_end)
  );

  // Clock and synchronous RAM model
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always_ff @(posedge sys_clk) ram_dout <= mem[address[1:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_run();
    for (int i = 0; i < 4; i++) exp_q.push_back(mem[i]);
  endtask

  // Waits for a start bit; leaves us at the negedge of its first low cycle.
  task automatic wait_start(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge sys_clk);
      if (uart_txd === 1'b0) seen = 1'b1;
    end
    check({tag, "_start_seen"}, 32'(seen), 32'd1);
  endtask

  // Samples a whole frame cycle by cycle and compares with the ideal waveform.
  task automatic recv_frame(input string tag);
    logic       s [FRAME];
    logic [9:0] frame;
    logic [7:0] exp_b;
    logic [7:0] got_b;
    int         bad;
    exp_b = exp_q.pop_front();
    frame = {1'b1, exp_b, 1'b0};
    s[0] = uart_txd;
    for (int i = 1; i < FRAME; i++) begin
      @(negedge sys_clk);
      s[i] = uart_txd;
    end
    bad = 0;
    for (int i = 0; i < FRAME; i++) if (s[i] !== frame[i / BPS]) bad++;
    for (int b = 0; b < 8; b++) got_b[b] = s[(b + 1) * BPS + BPS / 2];
    check({tag, "_byte"}, 32'(got_b), 32'(exp_b));
    check({tag, "_shape_errs"}, 32'(bad), 32'd0);
  endtask

  task automatic wait_end(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge sys_clk);
      if (run_end === 1'b1) seen = 1'b1;
    end
    check({tag, "_end_rise"}, 32'(seen), 32'd1);
    check({tag, "_addr_zero"}, 32'(address), 32'd0);
  endtask

  initial begin
    int lows;
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h00; mem[3] = 8'hFF;
    n_checks  = 0;
    n_errors  = 0;
    start     = 1'b0;
    sys_rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_end", 32'(run_end), 32'd0);
    check("rst_addr", 32'(address), 32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("idle_no_start_txd", 32'(uart_txd), 32'd1);

    // Run 1: full four-byte run, first frame checked bit-exact
    start = 1'b1;
    push_run();
    for (int k = 0; k < 4; k++) begin
      wait_start($sformatf("r1_b%0d", k));
      recv_frame($sformatf("r1_b%0d", k));
    end
    check("r1_end_not_early", 32'(run_end), 32'd0);
    wait_end("r1");

    // Start held high after end: no new frames, end stays set
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (uart_txd !== 1'b1) lows++;
    end
    check("hold_no_frames", 32'(lows), 32'd0);
    check("hold_end_high", 32'(run_end), 32'd1);

    start = 1'b0;
    @(negedge sys_clk);
    check("end_clears", 32'(run_end), 32'd0);

    // Run 2: start dropped during byte 1 must not abort
    @(negedge sys_clk);
    start = 1'b1;
    push_run();
    wait_start("r2_b0");
    recv_frame("r2_b0");
    wait_start("r2_b1");
    start = 1'b0;
    recv_frame("r2_b1");
    for (int k = 2; k < 4; k++) begin
      wait_start($sformatf("r2_b%0d", k));
      recv_frame($sformatf("r2_b%0d", k));
    end
    wait_end("r2");
    @(negedge sys_clk);
    check("r2_end_clears", 32'(run_end), 32'd0);

    // Run 3: reset during data bit 3 of byte 2
    start = 1'b1;
    push_run();
    for (int k = 0; k < 2; k++) begin
      wait_start($sformatf("r3_b%0d", k));
      recv_frame($sformatf("r3_b%0d", k));
    end
    wait_start("r3_b2");
    repeat (4 * BPS + 4) @(negedge sys_clk);
    check("r3_in_bit3_low", 32'(uart_txd), 32'd0);
    sys_rst_n = 1'b0;
    #1;
    check("r3_rst_txd", 32'(uart_txd), 32'd1);
    check("r3_rst_end", 32'(run_end), 32'd0);
    check("r3_rst_addr", 32'(address), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Run 4: restarts from address 0
    push_run();
    for (int k = 0; k < 4; k++) begin
      wait_start($sformatf("r4_b%0d", k));
      recv_frame($sformatf("r4_b%0d", k));
    end
    wait_end("r4");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/r_ram_to_uart.md
R_RAM_TO_UART -- requirements
Module: r_ram_to_uart

Interface
REQ-001 SHALL have parameter FULL_NUMBER, default 6416; number of bytes read and sent per run.
REQ-002 SHALL have parameter CLK_FREQ, default 50000000; sys_clk frequency in Hz.
REQ-003 SHALL have parameter UART_BPS, default 115200; baud rate.
REQ-004 SHALL have port sys_clk, input, 1: clock, all logic on rising edge.
REQ-005 SHALL have port sys_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port r_ram_to_uart_start, input, 1: level enable for a transfer run.
REQ-007 SHALL have port ram_dout, input, 8: RAM read data, valid 1 cycle after address (synchronous BRAM, no output register).
REQ-008 SHALL have port address, output, 15: RAM read address, equal to internal byte counter.
REQ-009 SHALL have port uart_txd, output, 1: serial line, 8N1, LSB first, idle high.
REQ-010 SHALL have port r_ram_to_uart_end, output, 1: run-complete flag.

Function
REQ-011 SHALL use FSM states IDLE, RD_ADDR, RD_WAIT, LOAD, TX_WAIT, NEXT, DONE.
REQ-012 IDLE: advance to RD_ADDR only when start=1 and end=0; otherwise hold.
REQ-013 RD_ADDR: address stable for one cycle -> RD_WAIT.
REQ-014 RD_WAIT: capture ram_dout into 8-bit tx_data register, then LOAD.
REQ-015 LOAD: one-cycle pulse of tx_en to uart_tx with tx_data -> TX_WAIT.
REQ-016 TX_WAIT: wait for falling edge of tx_busy (frame incl. stop bit finished) -> NEXT.
REQ-017 NEXT: counter == FULL_NUMBER-1 -> DONE; else counter+1 -> RD_ADDR.
REQ-018 DONE: counter<=0, end<=1, -> IDLE.
REQ-019 end SHALL remain 1 until start is sampled 0, then clear next cycle; no new run while end=1.
REQ-020 start deasserted mid-run SHALL NOT abort; run completes all FULL_NUMBER bytes.
REQ-021 Counter 15-bit unsigned; SHALL never exceed FULL_NUMBER-1; FULL_NUMBER range 1..32768.
REQ-022 Bytes SHALL be sent in address order 0..FULL_NUMBER-1, each exactly once, no gaps beyond one idle bit-time max between frames.
REQ-023 Bit period SHALL be BPS_CNT = CLK_FREQ/UART_BPS cycles (integer division; 434 at defaults).
REQ-024 Frame: start bit 0, data[0]..data[7], stop bit 1; total 10*BPS_CNT cycles.
REQ-025 tx_en while tx_busy=1 SHALL be ignored by uart_tx (FSM never issues it).

Reset
REQ-026 On sys_rst_n=0: state=IDLE, counter=0 (address=0), tx_data=0, end=0, uart_txd=1, tx_busy=0, baud/bit counters 0.
REQ-027 Reset mid-frame SHALL force uart_txd=1 immediately (asynchronous) and discard the run; next run restarts at address 0.

Structure
REQ-028 Shared package SHALL hold FSM state encoding, FULL_NUMBER default, CLK_FREQ/UART_BPS defaults, BPS_CNT derivation.
REQ-029 One sub-module uart_tx (sys_clk, sys_rst_n, tx_en, tx_data[7:0] -> uart_txd, tx_busy), counterpart of the existing uart_rx.
REQ-030 Top SHALL contain only FSM, counter, data register and the uart_tx instance.

Verification
REQ-031 Bench params FULL_NUMBER=4, CLK_FREQ=16, UART_BPS=1 (BPS_CNT=16); RAM model mem[0..3]=8'hA5,8'h3C,8'h00,8'hFF.
REQ-032 Reset, start=1 -> txd decodes A5,3C,00,FF in order; end rises after last stop bit; address returns 0.
REQ-033 Single frame of 8'hA5 -> txd low 16 cycles, then 1,0,1,0,0,1,0,1 each 16 cycles, then high 16 cycles.
REQ-034 Hold start=1 after end -> no further frames, end stays 1; drop start -> end=0 next cycle; reassert -> second identical 4-byte run.
REQ-035 Drop start during byte 1 -> remaining bytes still sent, end asserts.
REQ-036 Assert sys_rst_n=0 during data bit 3 of byte 2 -> txd=1 same cycle, end=0, address=0; subsequent start sends from A5.
